sample_delay_buf: RTL

Parametrised single-clock sample delay line built on an inferred simple dual-port RAM. Each accepted input sample is written to a circular buffer. The sample accepted `delay` inputs earlier is read back and presented alongside the current sample, so downstream autocorrelation logic (for example, short training sequence coarse-CFO estimation, delay 16) can form x[n]·conj(x[n−D]). Compared with the plain dual-port RAM it adds:
- a runtime-programmable delay,
- valid tracking with a fill/priming count,
- flush,
- a selectable output register stage.

---
 rtl/sample_delay_buf.sv | 114 +++++++++++
 1 files changed

// File: rtl/sample_delay_buf.sv
// Sample delay line: each accepted sample is stored in a circular RAM and presented
// together with the sample accepted `delay` inputs earlier (for x[n]*conj(x[n-D]) style products).
module sample_delay_buf #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 64,
  parameter  int OUTPUT_REG = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [AW-1:0]         delay,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data_cur,
  output logic [DATA_WIDTH-1:0] m_data_dly,
  output logic                  primed,
  output logic [AW-1:0]         fill_cnt
);

  localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         fill_q, fill_d;
  logic [AW-1:0]         d_q, d_eff;
  logic [AW-1:0]         rd_addr;
  logic                  chg, clr, accept, emit;
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] cur1_q, dly1_q;

  always_comb begin
    // NOTE: every variable written here is given a value on all paths (default first), so no latch is inferred.
    fill_d   = fill_q;
    d_eff    = (delay == '0) ? AW'(1) : delay;
    chg      = (d_eff != d_q);
    clr      = flush || chg;
    accept   = s_valid && !flush;
    // An output exists only once the delayed sample has been stored since the last clear.
    emit     = accept && !chg && (fill_q >= d_q);
    rd_addr  = wr_ptr_q - d_q;
    wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    if (clr) begin
      fill_d = accept ? AW'(1) : '0;
    end else if (accept && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + AW'(1);
    end
  end

  // NOTE: the sample memory has no reset; stale entries are never presented because
  // fill_cnt gates every read that reaches the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      d_q      <= AW'(1);
      v1_q     <= 1'b0;
      cur1_q   <= '0;
      dly1_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      d_q      <= d_eff;
      v1_q     <= emit;
      if (emit) begin
        cur1_q <= s_data;
        dly1_q <= mem_q[rd_addr];
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic                  v2_q;
      logic [DATA_WIDTH-1:0] cur2_q, dly2_q;

      // A clear also kills the beat sitting in the first stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2_q   <= 1'b0;
          cur2_q <= '0;
          dly2_q <= '0;
        end else begin
          v2_q <= v1_q && !clr;
          if (v1_q && !clr) begin
            cur2_q <= cur1_q;
            dly2_q <= dly1_q;
          end
        end
      end

      assign m_valid    = v2_q;
      assign m_data_cur = cur2_q;
      assign m_data_dly = dly2_q;
    end else begin : g_no_out_reg
      assign m_valid    = v1_q;
      assign m_data_cur = cur1_q;
      assign m_data_dly = dly1_q;
    end
  endgenerate

  assign fill_cnt = fill_q;
  assign primed   = (fill_q >= d_q);

endmodule
